// File: rtl/rdid_pkg.sv
// rdid_pkg: shared state type and constants
// for the JEDEC RDID SPI master.
package rdid_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD
  } state_t;

  localparam logic [7:0] CMD_RDID   = 8'h9F;
  localparam int         CMD_BITS   = 8;
  localparam int         RESP_BITS  = 24;
  localparam int         TOTAL_BITS = 32;

endpackage

// File: rtl/rdid_sclk_gen.sv
// rdid_sclk_gen: half-period counter and
// registered SCLK with rise/fall strobes.
module rdid_sclk_gen
  import rdid_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cnt_en,
  input  logic tgl_en,
  output logic tick,
  output logic rise,
  output logic fall,
  output logic sclk
);

  localparam int W = $clog2(CLK_DIV + 1);
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         sclk_q, sclk_d;

  assign tick = cnt_en && (cnt_q == LAST);
  assign rise = tick && tgl_en && !sclk_q;
  assign fall = tick && tgl_en && sclk_q;
  assign sclk = sclk_q;

  // count half-periods; toggle SCLK on wrap
  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (!cnt_en) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else if (tick) begin
      cnt_d = '0;
      if (tgl_en) sclk_d = !sclk_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // counter and SCLK flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/rdid_spi_master.sv
// rdid_spi_master: issues RDID (0x9F) in SPI
// mode 0 and latches the three ID bytes.
module rdid_spi_master
  import rdid_pkg::*;
#(
  parameter int         CLK_DIV = 4,
  parameter logic [7:0] CMD     = CMD_RDID
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       spi_sclk,
  output logic       spi_cs_n,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic [7:0] manufacture_id,
  output logic [7:0] memory_type,
  output logic [7:0] memory_capacity,
  output logic       busy,
  output logic       done
);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("CLK_DIV must be >= 1");
  end

  state_t state_q, state_d;
  logic cs_n_q, cs_n_d;
  logic mosi_q, mosi_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic fin_q, fin_d;
  logic [5:0] bit_q, bit_d;
  logic [7:0] cmd_q, cmd_d;
  logic [RESP_BITS-1:0] shift_q, shift_d;
  logic [RESP_BITS-1:0] id_q, id_d;
  logic tick, rise, fall;

  rdid_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk (
    .clk   (clk),
    .rst_n (rst_n),
    .cnt_en(state_q != IDLE),
    .tgl_en(state_q == SHIFT),
    .tick  (tick),
    .rise  (rise),
    .fall  (fall),
    .sclk  (spi_sclk)
  );

  assign spi_cs_n        = cs_n_q;
  assign spi_mosi        = mosi_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign manufacture_id  = id_q[23:16];
  assign memory_type     = id_q[15:8];
  assign memory_capacity = id_q[7:0];

  // transaction sequencing and shifting
  always_comb begin
    state_d = state_q;
    cs_n_d  = cs_n_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    fin_d   = fin_q;
    bit_d   = bit_q;
    cmd_d   = cmd_q;
    shift_d = shift_q;
    id_d    = id_q;
    unique case (state_q)
      IDLE: begin
        if (start && !done_q) begin
          state_d = SETUP;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          mosi_d  = CMD[7];
          cmd_d   = {CMD[6:0], 1'b0};
          bit_d   = '0;
          fin_d   = 1'b0;
        end
      end
      SETUP: begin
        if (tick) state_d = SHIFT;
      end
      SHIFT: begin
        if (rise && bit_q >= 6'(CMD_BITS))
          shift_d = {shift_q[RESP_BITS-2:0], spi_miso};
        if (fall) begin
          mosi_d = cmd_q[7];
          cmd_d  = {cmd_q[6:0], 1'b0};
          if (bit_q == 6'(TOTAL_BITS - 1)) begin
            state_d = HOLD;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 6'd1;
          end
        end
      end
      HOLD: begin
        if (fin_q) begin
          state_d = IDLE;
          cs_n_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          mosi_d  = 1'b0;
          fin_d   = 1'b0;
          id_d    = shift_q;
        end else if (tick) begin
          fin_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cs_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fin_q   <= 1'b0;
      bit_q   <= '0;
      cmd_q   <= '0;
      shift_q <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      cs_n_q  <= cs_n_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fin_q   <= fin_d;
      bit_q   <= bit_d;
      cmd_q   <= cmd_d;
      shift_q <= shift_d;
      id_q    <= id_d;
    end
  end

endmodule

// File: tb/tb_rdid_spi_master.sv
// tb_rdid_spi_master: two DUTs (CLK_DIV 4 and 1)
// against a behavioural RDID flash model.
module tb_rdid_spi_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] start = '0;
  wire  [1:0] sclk, cs_n, mosi, busy, done, miso;
  logic [7:0] mid [2];
  logic [7:0] mty [2];
  logic [7:0] mcap [2];

  logic [23:0] resp_a [2];
  int          mode_a [2];
  logic [23:0] exp_prev [2];
  int          t0 [2];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  bit          hold = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rdid_spi_master #(.CLK_DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start[0]),
    .spi_sclk(sclk[0]), .spi_cs_n(cs_n[0]),
    .spi_mosi(mosi[0]), .spi_miso(miso[0]),
    .manufacture_id(mid[0]), .memory_type(mty[0]),
    .memory_capacity(mcap[0]),
    .busy(busy[0]), .done(done[0])
  );

  rdid_spi_master #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]),
    .spi_sclk(sclk[1]), .spi_cs_n(cs_n[1]),
    .spi_mosi(mosi[1]), .spi_miso(miso[1]),
    .manufacture_id(mid[1]), .memory_type(mty[1]),
    .memory_capacity(mcap[1]),
    .busy(busy[1]), .done(done[1])
  );

  function automatic logic bitval(int g, int r);
    logic [23:0] v;
    v = resp_a[g];
    if (mode_a[g] == 1) return 1'b1;
    if (mode_a[g] == 2) return 1'b0;
    if (r >= 8 && r < 32) return v[31-r];
    return 1'b0;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : fl
    int rises = 0;
    int rise_out = 0;
    int mosi_bad = 0;
    logic [7:0] cmd = '0;
    logic m = 1'b0;
    logic cs_p = 1'b1;
    logic sc_p = 1'b0;
    always @(cs_n[g] or sclk[g]) begin
      if (cs_p === 1'b1 && cs_n[g] === 1'b0) begin
        rises = 0;
        cmd = '0;
        mosi_bad = 0;
        m = bitval(g, 0);
      end
      if (sc_p === 1'b0 && sclk[g] === 1'b1) begin
        if (cs_n[g] !== 1'b0) rise_out++;
        else begin
          if (rises < 8) cmd = {cmd[6:0], mosi[g]};
          else if (mosi[g] !== 1'b0) mosi_bad++;
          rises++;
        end
      end
      if (sc_p === 1'b1 && sclk[g] === 1'b0 && cs_n[g] === 1'b0)
        m = bitval(g, rises);
      cs_p = cs_n[g];
      sc_p = sclk[g];
    end
    assign miso[g] = m;
  end

  function automatic logic [23:0] ids_of(int d);
    return {mid[d], mty[d], mcap[d]};
  endfunction

  function automatic int rises_of(int d);
    return d != 0 ? fl[1].rises : fl[0].rises;
  endfunction

  function automatic int rout_of(int d);
    return d != 0 ? fl[1].rise_out : fl[0].rise_out;
  endfunction

  function automatic int mbad_of(int d);
    return d != 0 ? fl[1].mosi_bad : fl[0].mosi_bad;
  endfunction

  function automatic logic [7:0] cmd_of(int d);
    return d != 0 ? fl[1].cmd : fl[0].cmd;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic acc_chk(input int d);
    logic [7:0] c;
    c = 8'h9F;
    t0[d] = cyc;
    chk("acc_csn", cs_n[d], 0);
    chk("acc_busy", busy[d], 1);
    chk("acc_mosi", mosi[d], c[7]);
  endtask

  task automatic kick(input int d);
    @(negedge clk);
    start[d] = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start[d] = 1'b0;
    acc_chk(d);
  endtask

  task automatic finish(input int d,
                        input logic [23:0] exp);
    int n, hi, bdrop, idchg, div;
    bit got;
    n = 0; hi = 0; bdrop = 0; idchg = 0;
    got = 1'b0;
    div = (d != 0) ? 1 : 4;
    while (n < 2000 && !got) begin
      @(posedge clk);
      #1;
      n++;
      if (done[d] === 1'b1) got = 1'b1;
      else begin
        if (sclk[d] === 1'b1) hi++;
        if (busy[d] !== 1'b1 || cs_n[d] !== 1'b0)
          bdrop++;
        if (ids_of(d) !== exp_prev[d]) idchg++;
      end
    end
    chk("done_seen", got, 1);
    chk("latency", cyc - t0[d], 66 * div + 1);
    chk("ids", ids_of(d), exp);
    chk("done_csn", cs_n[d], 1);
    chk("done_busy", busy[d], 0);
    chk("done_mosi", mosi[d], 0);
    chk("done_sclk", sclk[d], 0);
    chk("cmd_byte", cmd_of(d), 8'h9F);
    chk("sclk_rises", rises_of(d), 32);
    chk("mosi_tail", mbad_of(d), 0);
    chk("rise_no_cs", rout_of(d), 0);
    chk("sclk_high", hi, 32 * div);
    chk("busy_mid", bdrop, 0);
    chk("ids_mid", idchg, 0);
    exp_prev[d] = exp;
    @(posedge clk);
    #1;
    chk("done_pulse", done[d], 0);
    chk("ids_after", ids_of(d), exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [23:0] r1, r2;
    for (int d = 0; d < 2; d++) begin
      resp_a[d] = '0;
      mode_a[d] = 0;
      exp_prev[d] = '0;
      t0[d] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_csn", cs_n[d], 1);
      chk("rst_sclk", sclk[d], 0);
      chk("rst_mosi", mosi[d], 0);
      chk("rst_busy", busy[d], 0);
      chk("rst_done", done[d], 0);
      chk("rst_ids", ids_of(d), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    resp_a[0] = 24'hEF4018;
    kick(0);
    finish(0, 24'hEF4018);

    resp_a[0] = 24'hC22017;
    kick(0);
    finish(0, 24'hC22017);

    r1 = 24'($urandom);
    r2 = 24'($urandom);
    resp_a[0] = r1;
    hold = 1'b1;
    kick(0);
    finish(0, r1);
    resp_a[0] = r2;
    n = 0;
    while (cs_n[0] === 1'b1 && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("restart_gap", n, 1);
    acc_chk(0);
    finish(0, r2);
    start[0] = 1'b0;
    hold = 1'b0;
    n = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (cs_n[0] !== 1'b1 || busy[0] !== 1'b0) n++;
    end
    chk("no_queue", n, 0);

    resp_a[0] = 24'hEF4018;
    kick(0);
    n = 0;
    while (fl[0].rises < 15 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("reach_edge15", fl[0].rises, 15);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_csn", cs_n[0], 1);
    chk("mrst_sclk", sclk[0], 0);
    chk("mrst_busy", busy[0], 0);
    chk("mrst_mosi", mosi[0], 0);
    chk("mrst_ids", ids_of(0), 0);
    chk("mrst_ids1", ids_of(1), 0);
    exp_prev[0] = '0;
    exp_prev[1] = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    kick(0);
    finish(0, 24'hEF4018);

    mode_a[0] = 1;
    kick(0);
    finish(0, 24'hFFFFFF);
    mode_a[0] = 2;
    kick(0);
    finish(0, 24'h000000);
    mode_a[0] = 0;

    resp_a[1] = 24'hC22017;
    kick(1);
    finish(1, 24'hC22017);

    for (int i = 0; i < 4; i++) begin
      int d;
      d = i % 2;
      r1 = 24'($urandom);
      resp_a[d] = r1;
      kick(d);
      finish(d, r1);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
